// File: rtl/spi_pkg.sv
// +--------------------------------------------------------------------------+
// | spi_pkg : SPI mode constants, CPOL/CPHA helpers and pin bundle type       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package spi_pkg;

    localparam int MODE0 = 0;
    localparam int MODE1 = 1;
    localparam int MODE2 = 2;
    localparam int MODE3 = 3;

    typedef struct packed {
        logic sck;
        logic cs;
        logic mosi;
    } spi_pins_t;

    function automatic logic spi_cpol(input int mode);
        return mode[1];
    endfunction

    function automatic logic spi_cpha(input int mode);
        return mode[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync.sv
// +--------------------------------------------------------------------------+
// | spi_sync : parametrised-width two-flop synchronizer with reset value      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module spi_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/spi_slave_sync.sv
// +--------------------------------------------------------------------------+
// | spi_slave_sync : oversampled SPI slave; transmit path built only when     |
// | SPI_SLAVE_TX_EN is defined.                               Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int SPI_MODE  = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SPI_CLK,
    input  logic              SPI_CS,
    input  logic              SPI_RX,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_VALID,
    input  logic              RX_READY,
    output logic              RX_OVERRUN,
    output logic              SPI_TX
`ifdef SPI_SLAVE_TX_EN
    ,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_LOAD,
    output logic              TX_READY,
    output logic              TX_UNDERRUN
`endif
);

    localparam logic              CPOL  = spi_cpol(SPI_MODE);
    localparam logic              CPHA  = spi_cpha(SPI_MODE);
    localparam int                CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

    spi_pins_t pins_raw;
    spi_pins_t pins_s;

    assign pins_raw.sck  = SPI_CLK;
    assign pins_raw.cs   = SPI_CS;
    assign pins_raw.mosi = SPI_RX;

    spi_sync #(
        .WIDTH   (3),
        .RST_VAL ({CPOL, 1'b1, 1'b0})
    ) u_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (pins_raw),
        .q_o   (pins_s)
    );

    logic              sck_prev_q;
    logic [1:0]        settle_q, settle_d;
    logic              armed_q, armed_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_ovr_q, rx_ovr_d;

    logic              lead_e, trail_e, sample_e, active;
    logic [DATA_W-1:0] shin;

    always_comb begin
        lead_e   = CPOL ? (~pins_s.sck & sck_prev_q) : (pins_s.sck & ~sck_prev_q);
        trail_e  = CPOL ? (pins_s.sck & ~sck_prev_q) : (~pins_s.sck & sck_prev_q);
        sample_e = CPHA ? trail_e : lead_e;
        // Reception is only enabled once CS has been seen high after reset,
        // so a word aborted by reset cannot resume without a fresh CS fall.
        active   = armed_q & ~pins_s.cs;
        shin     = (MSB_FIRST != 0) ? {shreg_q[DATA_W-2:0], pins_s.mosi}
                                    : {pins_s.mosi, shreg_q[DATA_W-1:1]};
    end

    always_comb begin
        settle_d   = {settle_q[0], 1'b1};
        armed_d    = armed_q | (settle_q[1] & pins_s.cs);
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~RX_READY;
        rx_ovr_d   = 1'b0;
        if (!active) begin
            cnt_d   = '0;
            shreg_d = '0;
        end else if (sample_e) begin
            shreg_d = shin;
            if (cnt_q == LAST) begin
                cnt_d      = '0;
                rx_data_d  = shin;
                rx_valid_d = 1'b1;
                rx_ovr_d   = rx_valid_q & ~RX_READY;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sck_prev_q <= CPOL;
            settle_q   <= '0;
            armed_q    <= 1'b0;
            cnt_q      <= '0;
            shreg_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            sck_prev_q <= pins_s.sck;
            settle_q   <= settle_d;
            armed_q    <= armed_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    assign RX_DATA    = rx_data_q;
    assign RX_VALID   = rx_valid_q;
    assign RX_OVERRUN = rx_ovr_q;

`ifdef SPI_SLAVE_TX_EN
    logic              cs_prev_q;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] txsh_q, txsh_d;
    logic              undr_q, undr_d;
    logic              shift_e, word_start;

    always_comb begin
        shift_e     = CPHA ? lead_e : trail_e;
        // A new word begins on the first shift edge after a completed word;
        // with CPHA=0 the first word must already be on MISO at CS fall.
        word_start  = active & ((shift_e & (cnt_q == '0)) | (~CPHA & cs_prev_q));
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        txsh_d      = txsh_q;
        undr_d      = 1'b0;
        if (!active) begin
            txsh_d = '0;
        end else if (word_start) begin
            txsh_d      = hold_full_q ? hold_q : '0;
            hold_full_d = 1'b0;
            undr_d      = ~hold_full_q;
        end else if (shift_e) begin
            txsh_d = (MSB_FIRST != 0) ? (txsh_q << 1) : (txsh_q >> 1);
        end
        if (TX_LOAD && !hold_full_q) begin
            hold_d      = TX_DATA;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cs_prev_q   <= 1'b1;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            txsh_q      <= '0;
            undr_q      <= 1'b0;
        end else begin
            cs_prev_q   <= pins_s.cs;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            txsh_q      <= txsh_d;
            undr_q      <= undr_d;
        end
    end

    assign SPI_TX      = active & ((MSB_FIRST != 0) ? txsh_q[DATA_W-1] : txsh_q[0]);
    assign TX_READY    = ~hold_full_q;
    assign TX_UNDERRUN = undr_q;
`else
    assign SPI_TX = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/spi_slave_sync.md
SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 Parameter DATA_W, default 8, word length in bits, legal range 4..32.
REQ-002 Parameter SPI_MODE, default 0, SPI mode 0..3: CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].
REQ-003 Parameter MSB_FIRST, default 1; 1 = MSB first on the wire, 0 = LSB first.
REQ-004 CLK  in  1  system clock; all logic SHALL be on its rising edge.
REQ-005 RST  in  1  reset, synchronous and active-high.
REQ-006 SPI_CLK  in  1  asynchronous SCK from the master.
REQ-007 SPI_CS  in  1  asynchronous chip select, active-low.
REQ-008 SPI_RX  in  1  asynchronous MOSI.
REQ-009 RX_DATA  out  DATA_W  last completed received word.
REQ-010 RX_VALID  out  1  RX_DATA holds an unconsumed word.
REQ-011 RX_READY  in  1  consumer accepts RX_DATA when high together with RX_VALID.
REQ-012 RX_OVERRUN  out  1  one-cycle pulse: an unconsumed word was overwritten.
REQ-013 SPI_TX  out  1  MISO.
REQ-014 TX_DATA  in  DATA_W, TX_LOAD in 1, TX_READY out 1, TX_UNDERRUN out 1; present only with SPI_SLAVE_TX_EN.

Function
REQ-015 SPI_CLK, SPI_CS and SPI_RX SHALL each pass through a 2-flop synchronizer, plus one extra SPI_CLK flop for edge detection.
REQ-016 Leading edge = SCK leaving the CPOL level; sample edge = leading if CPHA=0, trailing if CPHA=1; shift edge = the other edge.
REQ-017 On each synchronized sample edge with CS low, the synchronized MOSI bit SHALL be shifted into the word in MSB_FIRST order and the bit counter incremented.
REQ-018 Latency: a pin SCK edge captured by the first sync flop at CLK edge n SHALL be acted on at CLK edge n+2.
REQ-019 On the DATA_W-th sample edge: RX_DATA <= completed word, RX_VALID <= 1, counter <= 0; reception SHALL continue into the next word without CS deassertion.
REQ-020 RX_VALID SHALL clear at the CLK edge where RX_VALID and RX_READY are both high.
REQ-021 If a word completes while RX_VALID=1 and RX_READY=0, RX_DATA SHALL be overwritten, RX_VALID SHALL stay 1, and RX_OVERRUN SHALL pulse for one cycle; if RX_READY=1 in that cycle, there is no overrun and RX_VALID stays 1.
REQ-022 A synchronized CS rise SHALL discard the partial word and clear the counter; RX_DATA and RX_VALID are unaffected.
REQ-023 SCK edges while synchronized CS is high SHALL be ignored.
REQ-024 SPI_TX SHALL be 0 while synchronized CS is high.
REQ-025 Operating constraint: SCK high and low phases SHALL each be at least 3 CLK periods.

Reset
REQ-026 On RST=1 at a CLK edge: RX_DATA=0, RX_VALID=0, RX_OVERRUN=0, counter=0, shift registers=0, sync flops=idle (SCK=CPOL, CS=1, RX=0), SPI_TX=0, TX_READY=1, TX_UNDERRUN=0.
REQ-027 RST mid-word SHALL abort the word; the next word SHALL start only after a new CS fall.

Configuration
REQ-028 Macro SPI_SLAVE_TX_EN defined: the transmit path is built.
 - TX_LOAD with TX_READY=1 latches TX_DATA into a holding register and sets TX_READY=0.
 - Holding register moves to the TX shifter at word start (CS fall for CPHA=0, first leading edge for CPHA=1), setting TX_READY=1.
 - Bits drive SPI_TX on shift edges, MSB_FIRST order.
 - Word start with an empty holding register sends all-zero and pulses TX_UNDERRUN.
REQ-029 Macro SPI_SLAVE_TX_EN undefined: TX ports are absent, SPI_TX is tied to 0, and no transmit flops exist.

Structure
REQ-030 Package spi_pkg SHALL hold the SPI mode constants (MODE0..MODE3) and the CPOL/CPHA extraction functions.
REQ-031 Sub-module spi_sync (parametrised-width 2-flop synchronizer with reset value) SHALL be instantiated for the three pin inputs.

Verification
REQ-032 Mode 0, DATA_W=8, MSB first, send 0xA5 with RX_READY=1 -> exactly one RX_VALID, RX_DATA=0xA5, accepted the same cycle.
REQ-033 Mode 3, LSB first, two back-to-back words 0x3C, 0xC3 under one CS -> RX_DATA 0x3C then 0xC3, no overrun.
REQ-034 RX_READY=0, two words 0x11, 0x22 -> RX_OVERRUN pulses once, RX_DATA=0x22, RX_VALID=1.
REQ-035 CS raised after 5 bits of 0xFF, then full word 0x0F -> only 0x0F is reported.
REQ-036 With SPI_SLAVE_TX_EN, mode 1: TX_LOAD 0x5A, then exchange one word -> master receives 0x5A; second word with no load -> master receives 0x00 and TX_UNDERRUN pulses.
REQ-037 RST asserted mid-word, then full word 0x81 -> outputs at reset values after RST, then RX_DATA=0x81.
